// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes, instruction field offsets and FSM states
// for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int WORD_W = 1 + OP_W + 2 * DATA_W;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OP_W-1:0] OP_LTH = 4'b0110;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b0111;

    localparam int USE_ACC_BIT = 20;
    localparam int OP_MSB      = 19;
    localparam int OP_LSB      = 16;
    localparam int A_MSB       = 15;
    localparam int A_LSB       = 8;
    localparam int B_MSB       = 7;
    localparam int B_LSB       = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the ALU (slave).
interface alu_operand_sequencer_if;
    import alu_seq_pkg::*;

    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output alu_opcode,
        output alu_a,
        output alu_b,
        input  alu_result
    );

    modport slave (
        input  alu_opcode,
        input  alu_a,
        input  alu_b,
        output alu_result
    );

endinterface

// File: rtl/alu_operand_sequencer_prog_buffer.sv
// Instruction slots filled in order; count doubles as the write pointer.
module prog_buffer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       clr,
    input  logic [WORD_W-1:0]          wr_word,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WORD_W-1:0]          rd_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_word = mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_en && !full) begin
            mem_d[count_q[IW-1:0]] = wr_word;
            count_d = count_q + CW'(1);
        end
    end

    // Slot contents need no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issues a stored ALU program one instruction at a time and
// captures each result, optionally chaining it into the next operand A.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [WORD_W-1:0]          load_word,
    input  logic                       clear,
    input  logic                       start,
    alu_operand_sequencer_if.master    alu,
    output logic [DATA_W-1:0]          acc,
    output logic                       busy,
    output logic                       done,
    output logic                       load_err,
    output logic [$clog2(DEPTH+1)-1:0] prog_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    seq_state_e        state_q, state_d;
    logic [IW-1:0]     pc_q, pc_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lerr_q, lerr_d;

    logic [WORD_W-1:0] rd_word;
    logic [IW-1:0]     rd_idx;
    logic [CW-1:0]     count;
    logic              full;
    logic              running;
    logic              wr_en;
    logic              clr;

    assign running = (state_q == ISSUE) || (state_q == WAIT);
    assign wr_en   = load_en && !clear && !running;
    assign clr     = clear && (state_q == IDLE);
    // Outside IDLE the only slot needed is the next one after pc.
    assign rd_idx  = (state_q == IDLE) ? '0 : pc_q + IW'(1);

    prog_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .clr     (clr),
        .wr_word (load_word),
        .rd_idx  (rd_idx),
        .rd_word (rd_word),
        .count   (count),
        .full    (full)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lerr_d  = load_en && (running || (!clear && full));

        unique case (state_q)
            IDLE: begin
                if (start && count != '0) begin
                    pc_d    = '0;
                    op_d    = rd_word[OP_MSB:OP_LSB];
                    b_d     = rd_word[B_MSB:B_LSB];
                    a_d     = rd_word[USE_ACC_BIT] ? acc_q
                                                   : rd_word[A_MSB:A_LSB];
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end else if (start) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            ISSUE: begin
                wcnt_d  = 2'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q != 2'd0) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else begin
                    acc_d = alu.alu_result;
                    if (CW'(pc_q) == count - CW'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        pc_d    = pc_q + IW'(1);
                        op_d    = rd_word[OP_MSB:OP_LSB];
                        b_d     = rd_word[B_MSB:B_LSB];
                        // Chain the fresh result, not the acc flop.
                        a_d     = rd_word[USE_ACC_BIT] ? alu.alu_result
                                                       : rd_word[A_MSB:A_LSB];
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

    assign alu.alu_opcode = op_q;
    assign alu.alu_a      = a_q;
    assign alu.alu_b      = b_q;
    assign acc            = acc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign load_err       = lerr_q;
    assign prog_count     = count;

endmodule
